systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Output-side reader for the systolic array. It snapshots the flattened accumulator matrix when the array signals compute_done.
- It requantizes each op_width accumulator to out_width (rounded arithmetic shift, optional saturation).
- It streams the elements row-major over a valid/ready interface to the writeback path. This frees the array to start the next tile while results drain.

Parameters:
- rows, 16, array row count
- cols, 16, array column count
- op_width, 32, accumulator width per element (signed)
- out_width, 8, streamed element width (signed)
- shift_w, 5, width of shift control

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- compute_done  input  1  array done level; capture on its rising edge
- output_matrix  input  rows*cols*op_width  flattened accumulators, element (i,j) at bits [(i*cols+j)*op_width +: op_width]
- shift  input  shift_w  right-shift amount, sampled at capture
- sat_en  input  1  1 = saturate to out_width, 0 = truncate; sampled at capture
- out_valid  output  1  element available
- out_ready  input  1  downstream accept
- out_data  output  out_width  requantized element
- out_row  output  $clog2(rows)  row index of out_data
- out_col  output  $clog2(cols)  column index of out_data
- out_last  output  1  high with element (rows-1,cols-1)
- busy  output  1  snapshot held / streaming
- overrun  output  1  sticky: done edge arrived while busy and was dropped
- frames_count  output  32  completed frames (last element accepted)

Behaviour:
- Reset (rst=0, asynchronous) clears all state and outputs, effective immediately mid-stream:
  - out_valid, out_last, busy, overrun = 0
  - out_data, out_row, out_col = 0
  - frames_count = 0
  - done edge register = 0
  - FSM = IDLE
- Edge detect: done_q <= compute_done; capture event cap = compute_done & ~done_q.
  - If compute_done is held high from before reset release, it yields one event on the first post-reset cycle.
- FSM states IDLE, STREAM.
- IDLE:
  - On cap: latch output_matrix into the snapshot, latch shift and sat_en, set index to 0, go to STREAM.
  - busy=1 from the following cycle.
- STREAM:
  - out_valid=1. Element index k drives out_row=k/cols and out_col=k%cols.
  - Handshake = out_valid & out_ready. On handshake: k <= k+1.
  - out_data, out_row, out_col and out_last stay stable while out_valid & ~out_ready.
  - Handshake on k = rows*cols-1 (out_last=1): frames_count += 1 (wraps at 2^32).
    - If no cap in the same cycle: go to IDLE; out_valid and busy drop the next cycle.
    - If cap in the same cycle: recapture, k=0, stay in STREAM. out_valid stays high, with element 0 of the new frame the next cycle and no bubble. No overrun is flagged.
  - cap without a final handshake: ignore the cap, set overrun=1 (sticky until reset). The snapshot is unmodified.
- Latency: cap at edge N -> out_valid=1 with element (0,0) after edge N+1. Drain time is rows*cols cycles with out_ready held high.
- Requantize (combinational from snapshot element a, signed op_width):
  - s=0: r = a.
  - s>0: r = (a + 2^(s-1)) >>> s. The addition is computed in op_width+1 bits, so it cannot overflow.
  - sat_en=1: clamp r to [-2^(out_width-1), 2^(out_width-1)-1].
  - sat_en=0: out_data = r[out_width-1:0].
  - shift values >= op_width behave as op_width-1.
- Registered output stage: the element mux is registered so out_data is a flop output. The index counter is advanced one ahead internally to keep the stated latency.

Test Plan:
- Rows=2, cols=2 instance, out_ready=1. Elements [100,102,-6,7], shift=2, sat_en=1, pulse compute_done -> 4 beats [25,26,-1,2]; out_row/out_col (0,0),(0,1),(1,0),(1,1); out_last on beat 4 only; frames_count=1; busy low after.
- Saturation, shift=0. Elements [1000,-1000,127,-129]:
  - sat_en=1 -> [127,-128,127,-128].
  - sat_en=0 -> [-24,24,127,127] (low 8 bits).
- Backpressure: out_ready toggles 1,0,0,1,0,1... -> no element lost or duplicated. out_data and indices hold during every ready=0 cycle. Total 4 accepted beats.
- Overrun: second compute_done rising edge during beat 2 -> overrun=1. The stream completes with the original 4 values; frames_count=1.
- Back-to-back: new rising edge in the same cycle as the last handshake -> no overrun. out_valid never drops and the next beat is element (0,0) of the new frame; frames_count=2 after both frames.
- Reset mid-stream: assert rst=0 between clock edges on beat 2 -> out_valid, busy and frames_count go 0 without waiting for clk. After release, compute_done held high -> exactly one new frame streams.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: snapshots the accumulator matrix on the
// rising edge of compute_done, requantizes each element (rounded arithmetic
// shift, optional saturation) and streams the elements row-major over a
// valid/ready interface so the array can start the next tile meanwhile.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no snapshot held, waiting for a compute_done rising edge
// STREAM | snapshot held; priming the output stage or presenting elements
//
// rows and cols are expected to be at least 2 so the index ports are non-empty.
module systolic_result_drain #(
    parameter int rows      = 16,
    parameter int cols      = 16,
    parameter int op_width  = 32,
    parameter int out_width = 8,
    parameter int shift_w   = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            compute_done,
    input  logic [rows*cols*op_width-1:0]   output_matrix,
    input  logic [shift_w-1:0]              shift,
    input  logic                            sat_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [out_width-1:0]            out_data,
    output logic [$clog2(rows)-1:0]         out_row,
    output logic [$clog2(cols)-1:0]         out_col,
    output logic                            out_last,
    output logic                            busy,
    output logic                            overrun,
    output logic [31:0]                     frames_count
);

    localparam int total = rows * cols;
    localparam int kw    = $clog2(total);
    localparam int rw    = $clog2(rows);
    localparam int cw    = $clog2(cols);
    localparam logic [kw-1:0] last_k = kw'(total - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state_q, state_d;

    logic                done_q;
    logic                cap;
    logic                hs;
    logic                fin;
    logic [op_width-1:0] snap [total];
    logic [shift_w-1:0]  shift_q;
    logic                sat_q;
    // index of the element to be loaded into the output stage next
    logic [kw-1:0]       nxt_k;

    logic do_cap, do_load, load_bypass, drop_valid, set_ovr, count_frame;

    // Rounded arithmetic right shift in op_width+1 bits, then clamp or truncate.
    function automatic logic [out_width-1:0] requant(
        input logic [op_width-1:0] a,
        input logic [shift_w-1:0]  s,
        input logic                sat
    );
        logic [31:0]             sh;
        logic signed [op_width:0] ext;
        logic signed [op_width:0] rnd;
        logic signed [op_width:0] r;
        logic signed [op_width:0] hi;
        logic signed [op_width:0] lo;
        sh = 32'(s);
        if (sh > 32'(op_width - 1))
            sh = 32'(op_width - 1);
        ext = $signed({a[op_width-1], a});
        if (sh == 32'd0) begin
            r = ext;
        end else begin
            rnd = $signed((op_width+1)'(1) << (sh - 32'd1));
            r   = (ext + rnd) >>> sh;
        end
        hi = $signed((op_width+1)'((1 << (out_width - 1)) - 1));
        lo = -hi - 1;
        if (sat && (r > hi))
            requant = hi[out_width-1:0];
        else if (sat && (r < lo))
            requant = lo[out_width-1:0];
        else
            requant = r[out_width-1:0];
    endfunction

    assign cap = compute_done & ~done_q;
    assign hs  = out_valid & out_ready;
    assign fin = hs & out_last;

    // compute_done edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            done_q <= 1'b0;
        else
            done_q <= compute_done;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d     = state_q;
        do_cap      = 1'b0;
        do_load     = 1'b0;
        load_bypass = 1'b0;
        drop_valid  = 1'b0;
        set_ovr     = 1'b0;
        count_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    do_cap  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fin) begin
                    count_frame = 1'b1;
                    if (cap) begin
                        // back-to-back: element 0 comes straight from the inputs
                        do_cap      = 1'b1;
                        load_bypass = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    set_ovr = cap;
                    // first cycle after capture primes the output stage
                    do_load = ~out_valid | hs;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, output stage and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < total; i++)
                snap[i] <= '0;
            shift_q      <= '0;
            sat_q        <= 1'b0;
            nxt_k        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_row      <= '0;
            out_col      <= '0;
            out_last     <= 1'b0;
            overrun      <= 1'b0;
            frames_count <= '0;
        end else begin
            if (do_cap) begin
                for (int i = 0; i < total; i++)
                    snap[i] <= output_matrix[i*op_width +: op_width];
                shift_q <= shift;
                sat_q   <= sat_en;
                nxt_k   <= load_bypass ? kw'(1) : '0;
            end
            if (do_load) begin
                out_data  <= requant(snap[nxt_k], shift_q, sat_q);
                out_row   <= rw'(int'(nxt_k) / cols);
                out_col   <= cw'(int'(nxt_k) % cols);
                out_last  <= (nxt_k == last_k);
                out_valid <= 1'b1;
                nxt_k     <= nxt_k + kw'(1);
            end
            if (load_bypass) begin
                out_data <= requant(output_matrix[op_width-1:0], shift, sat_en);
                out_row  <= '0;
                out_col  <= '0;
                out_last <= (total == 1);
            end
            if (drop_valid) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (set_ovr)
                overrun <= 1'b1;
            if (count_frame)
                frames_count <= frames_count + 32'd1;
        end
    end

    assign busy = (state_q == STREAM);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain on a 2x2 instance. Expected beats
// are queued when a frame is launched and popped by a negedge monitor.
module tb_systolic_result_drain;

    localparam int rows      = 2;
    localparam int cols      = 2;
    localparam int op_width  = 32;
    localparam int out_width = 8;
    localparam int shift_w   = 5;

    logic                          clk;
    logic                          rst;
    logic                          compute_done;
    logic [rows*cols*op_width-1:0] output_matrix;
    logic [shift_w-1:0]            shift;
    logic                          sat_en;
    logic                          out_valid;
    logic                          out_ready;
    logic [out_width-1:0]          out_data;
    logic [$clog2(rows)-1:0]       out_row;
    logic [$clog2(cols)-1:0]       out_col;
    logic                          out_last;
    logic                          busy;
    logic                          overrun;
    logic [31:0]                   frames_count;

    typedef struct {
        int data;
        int row;
        int col;
        int last;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    systolic_result_drain #(
        .rows(rows), .cols(cols), .op_width(op_width),
        .out_width(out_width), .shift_w(shift_w)
    ) dut (
        .clk(clk), .rst(rst), .compute_done(compute_done),
        .output_matrix(output_matrix), .shift(shift), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .overrun(overrun), .frames_count(frames_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_matrix(input int e0, input int e1, input int e2, input int e3);
        output_matrix = {e3, e2, e1, e0};
    endtask

    task automatic push_frame(input int d0, input int d1, input int d2, input int d3);
        beat_t b;
        b = '{d0, 0, 0, 0}; sb.push_back(b);
        b = '{d1, 0, 1, 0}; sb.push_back(b);
        b = '{d2, 1, 0, 0}; sb.push_back(b);
        b = '{d3, 1, 1, 1}; sb.push_back(b);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (((sb.size() != 0) || busy) && (n < budget)) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_budget", int'(n < budget), 1);
    endtask

    // Scoreboard and hold-under-backpressure monitor
    initial begin
        logic                 stall_q;
        logic [out_width-1:0] data_q;
        logic [31:0]          row_q, col_q, last_q;
        beat_t                e;
        stall_q = 1'b0;
        data_q  = '0;
        row_q   = '0;
        col_q   = '0;
        last_q  = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_data", 32'($signed(out_data)), 32'($signed(data_q)));
                    check("hold_row", 32'(out_row), row_q);
                    check("hold_col", 32'(out_col), col_q);
                    check("hold_last", 32'(out_last), last_q);
                end
                if (out_valid && out_ready) begin
                    check("beat_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("beat_data", 32'($signed(out_data)), e.data);
                        check("beat_row", 32'(out_row), e.row);
                        check("beat_col", 32'(out_col), e.col);
                        check("beat_last", 32'(out_last), e.last);
                    end
                end
                stall_q = out_valid && !out_ready;
                data_q  = out_data;
                row_q   = 32'(out_row);
                col_q   = 32'(out_col);
                last_q  = 32'(out_last);
            end
        end
    end

    // Directed sequence
    initial begin
        int pat[6];
        int i;
        pat = '{1, 0, 0, 1, 0, 1};
        rst           = 1'b0;
        compute_done  = 1'b0;
        out_ready     = 1'b1;
        shift         = '0;
        sat_en        = 1'b0;
        output_matrix = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_row", 32'(out_row), 0);
        check("rst_col", 32'(out_col), 0);
        check("rst_frames", frames_count, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // basic rounded shift with latency check
        set_matrix(100, 102, -6, 7); shift = 5'd2; sat_en = 1'b1;
        push_frame(25, 26, -1, 2);
        compute_done = 1'b1;
        @(posedge clk); #1;
        check("lat_busy", 32'(busy), 1);
        check("lat_no_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 1);
        compute_done = 1'b0;
        wait_drain(20);
        check("basic_frames", frames_count, 1);
        check("basic_busy", 32'(busy), 0);
        check("basic_valid", 32'(out_valid), 0);
        check("basic_overrun", 32'(overrun), 0);

        // saturation, shift 0
        set_matrix(1000, -1000, 127, -129); shift = 5'd0; sat_en = 1'b1;
        push_frame(127, -128, 127, -128);
        compute_done = 1'b1;
        @(posedge clk); #1;
        compute_done = 1'b0;
        wait_drain(20);
        check("sat_frames", frames_count, 2);

        // truncation under backpressure 1,0,0,1,0,1...
        sat_en = 1'b0;
        push_frame(-24, 24, 127, 127);
        compute_done = 1'b1;
        i = 0;
        while (((sb.size() != 0) || busy || (i == 0)) && (i < 60)) begin
            out_ready = pat[i % 6][0];
            @(posedge clk); #1;
            compute_done = 1'b0;
            i++;
        end
        check("bp_in_budget", int'(i < 60), 1);
        out_ready = 1'b1;
        check("bp_frames", frames_count, 3);
        check("bp_sb_empty", sb.size(), 0);

        // overrun: new edge while beat 2 is presented
        set_matrix(100, 102, -6, 7); shift = 5'd2; sat_en = 1'b1;
        push_frame(25, 26, -1, 2);
        compute_done = 1'b1;
        @(posedge clk); #1;
        compute_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ovr_beat2_col", 32'(out_col), 1);
        set_matrix(5, 5, 5, 5); shift = 5'd0; sat_en = 1'b0;
        compute_done = 1'b1;
        @(posedge clk); #1;
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_still_valid", 32'(out_valid), 1);
        compute_done = 1'b0;
        wait_drain(20);
        check("ovr_frames", frames_count, 4);
        check("ovr_sticky", 32'(overrun), 1);

        // asynchronous reset mid-stream, compute_done held high across release
        set_matrix(1000, -1000, 127, -129); shift = 5'd0; sat_en = 1'b1;
        push_frame(127, -128, 127, -128);
        compute_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_beat2_col", 32'(out_col), 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_frames", frames_count, 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        sb.delete();
        push_frame(127, -128, 127, -128);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_drain(20);
        check("mid_frames", frames_count, 1);
        repeat (8) @(posedge clk);
        #1;
        check("mid_one_frame_busy", 32'(busy), 0);
        check("mid_one_frame_count", frames_count, 1);
        compute_done = 1'b0;

        // back-to-back frames with recapture on the final handshake
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        set_matrix(100, 102, -6, 7); shift = 5'd2; sat_en = 1'b1;
        push_frame(25, 26, -1, 2);
        compute_done = 1'b1;
        @(posedge clk); #1;
        compute_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_valid_a", 32'(out_valid), 1);
        end
        set_matrix(1000, -1000, 127, -129); shift = 5'd0; sat_en = 1'b1;
        push_frame(127, -128, 127, -128);
        compute_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_valid_b", 32'(out_valid), 1);
            compute_done = 1'b0;
        end
        wait_drain(20);
        check("b2b_frames", frames_count, 2);
        check("b2b_overrun", 32'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
